fallthrough_small_fifo: RTL and testbench
=========================================

FALLTHROUGH_SMALL_FIFO -- requirements
Module: fallthrough_small_fifo

Interface
REQ-001 Parameter WIDTH, default 72: data word width in bits.
REQ-002 Parameter MAX_DEPTH_BITS, default 3: log2 of capacity; MAX_DEPTH = 2**MAX_DEPTH_BITS words.
REQ-003 Parameter PROG_FULL_THRESHOLD, default MAX_DEPTH-1: occupancy at which prog_full asserts; legal range 1..MAX_DEPTH.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 din  input  WIDTH  write data.
REQ-007 wr_en  input  1  write request; pushes din at the clock edge.
REQ-008 rd_en  input  1  read request; pops the word currently on dout at the clock edge.
REQ-009 dout  output  WIDTH  head-of-queue word, valid whenever empty=0 (first-word fall-through).
REQ-010 full  output  1  occupancy == MAX_DEPTH.
REQ-011 nearly_full  output  1  occupancy >= MAX_DEPTH-1.
REQ-012 prog_full  output  1  occupancy >= PROG_FULL_THRESHOLD.
REQ-013 empty  output  1  occupancy == 0.

Function
REQ-014 Storage SHALL be a MAX_DEPTH x WIDTH array addressed by write and read pointers of MAX_DEPTH_BITS bits, each wrapping modulo MAX_DEPTH.
REQ-015 Occupancy counter SHALL be MAX_DEPTH_BITS+1 bits, range 0..MAX_DEPTH.
REQ-016 Accepted write: store din at write pointer, write pointer +1.
REQ-017 Accepted read: read pointer +1; dout shows the next stored word in the cycle after the edge.
REQ-018 dout SHALL be driven combinationally from the array at the read pointer; no rd_en needed to present the head word.
REQ-019 Latency: word written at edge N SHALL appear on dout with empty=0 immediately after edge N (readable at edge N+1).
REQ-020 Write while full and rd_en=0: write ignored, contents and pointers unchanged.
REQ-021 Read while empty: ignored, pointers unchanged; with simultaneous wr_en the write is still accepted.
REQ-022 Simultaneous wr_en and rd_en with 0 < occupancy <= MAX_DEPTH: both accepted, occupancy unchanged (write accepted even when full because a slot is freed the same edge).
REQ-023 Occupancy update: +1 write-only accepted, -1 read-only accepted, unchanged otherwise.
REQ-024 full, nearly_full, prog_full, empty SHALL be functions of registered occupancy only, valid the cycle after the causing edge.
REQ-025 dout while empty=1: don't-care; consumers SHALL NOT sample it.
REQ-026 Simulation-only checks: write-while-full and read-while-empty SHALL print an error message with time; excluded from synthesis.

Reset
REQ-027 Reset SHALL clear pointers and occupancy: empty=1, full=0, nearly_full=0, prog_full=0 after the reset edge.
REQ-028 Reset SHALL dominate wr_en/rd_en on the same edge; array contents not cleared.
REQ-029 Reset mid-operation SHALL discard all stored words; first post-reset write appears on dout per REQ-019.

Verification (WIDTH=72, MAX_DEPTH_BITS=2, PROG_FULL_THRESHOLD=3)
REQ-030 Reset, then single write 0x11 -> next cycle empty=0, dout=0x11 without rd_en; rd_en one cycle -> empty=1.
REQ-031 Write 0xA0..0xA3 back-to-back -> nearly_full=1 after 3rd, prog_full=1 after 3rd, full=1 after 4th; 5th write 0xA4 dropped; reads return A0,A1,A2,A3 then empty=1.
REQ-032 Full (4 words), wr_en+rd_en same cycle with din=0xB0 -> occupancy stays 4, full=1; drain yields A1,A2,A3,B0.
REQ-033 Empty FIFO, wr_en+rd_en same cycle with din=0xC0 -> occupancy 1, dout=0xC0.
REQ-034 Continuous streaming 16 words 0x00..0x0F with rd_en whenever empty=0 -> output order 0x00..0x0F, pointer wrap invisible, no loss.
REQ-035 Load 3 words, assert reset with wr_en=1 -> after edge empty=1, all flags 0; previous words never appear.

Source files
------------

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fallthrough_small_fifo
//  Purpose  : Small synchronous FIFO with first-word fall-through. The head
//             word is presented combinationally on dout whenever the FIFO is
//             non-empty, so no rd_en is needed to see it. rd_en pops that word.
//  Ports    : clk         - clock, all state changes on the rising edge
//             reset       - synchronous, active-high; clears pointers/occupancy
//             din         - write data (WIDTH bits)
//             wr_en       - push din at the clock edge
//             rd_en       - pop the word currently on dout at the clock edge
//             dout        - head-of-queue word, valid while empty = 0
//             full        - occupancy == MAX_DEPTH
//             nearly_full - occupancy >= MAX_DEPTH-1
//             prog_full   - occupancy >= PROG_FULL_THRESHOLD
//             empty       - occupancy == 0
//  Revision : 1.0 - initial release
// ============================================================================
module fallthrough_small_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = (2**MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;

    localparam logic [MAX_DEPTH_BITS:0] C_DEPTH_MAX  = (MAX_DEPTH_BITS+1)'(MAX_DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] C_DEPTH_NF   = (MAX_DEPTH_BITS+1)'(MAX_DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS:0] C_DEPTH_PROG = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);

    // Storage and pointers. The array has no reset: stale words are simply
    // unreachable once the pointers and occupancy are cleared.
    logic [WIDTH-1:0]          mem_q [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   depth_q,  depth_d;

    logic wr_accept;
    logic rd_accept;

    // A write while full is still accepted when a read frees a slot on the
    // same edge; a read while empty is always ignored.
    always_comb begin
        rd_accept = rd_en && !empty;
        wr_accept = wr_en && (!full || rd_en);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        depth_d  = depth_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_accept && !rd_accept) begin
            depth_d = depth_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            depth_q  <= depth_d;
        end
    end

    // Reset also blocks the array write so a reset edge never lands data.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Fall-through: the head word is read straight from the array.
    assign dout = mem_q[rd_ptr_q];

    // Status flags depend only on registered occupancy.
    assign full        = (depth_q == C_DEPTH_MAX);
    assign nearly_full = (depth_q >= C_DEPTH_NF);
    assign prog_full   = (depth_q >= C_DEPTH_PROG);
    assign empty       = (depth_q == '0);

`ifndef SYNTHESIS
    // Protocol diagnostics for simulation only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en && full && !rd_en) begin
                $display("%0t %m: write while full, word dropped", $time);
            end
            if (rd_en && empty) begin
                $display("%0t %m: read while empty, ignored", $time);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fallthrough_small_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fallthrough_small_fifo
//  Purpose  : Directed self-checking bench for fallthrough_small_fifo with
//             WIDTH=72, MAX_DEPTH_BITS=2 (depth 4), PROG_FULL_THRESHOLD=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fallthrough_small_fifo;

    localparam int WIDTH = 72;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             prog_full;
    logic             empty;

    int checks;
    int errors;

    fallthrough_small_fifo #(
        .WIDTH               (WIDTH),
        .MAX_DEPTH_BITS      (2),
        .PROG_FULL_THRESHOLD (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .nearly_full (nearly_full),
        .prog_full   (prog_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the four flags at once: {full, nearly_full, prog_full, empty}.
    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, WIDTH'({full, nearly_full, prog_full, empty}), WIDTH'(exp));
    endtask

    // Apply inputs, clock one edge, and settle 1 time unit after it.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int wi;
        int ri;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;

        // Reset state
        step(0, 0, 0);
        step(0, 0, 0);
        check_flags("reset_flags", 4'b0001);
        reset = 1'b0;

        // Single write falls through without rd_en
        step(1, 0, 72'h11);
        check_flags("single_wr_flags", 4'b0000);
        check("single_wr_dout", dout, 72'h11);
        step(0, 0, 0);
        check("single_hold_dout", dout, 72'h11);
        step(0, 1, 0);
        check_flags("single_rd_empty", 4'b0001);

        // Fill to full, flag thresholds, overflow write dropped
        step(1, 0, 72'hA0);
        check_flags("fill1_flags", 4'b0000);
        step(1, 0, 72'hA1);
        check_flags("fill2_flags", 4'b0000);
        step(1, 0, 72'hA2);
        check_flags("fill3_flags", 4'b0110);
        step(1, 0, 72'hA3);
        check_flags("fill4_flags", 4'b1110);
        step(1, 0, 72'hA4);
        check_flags("overflow_flags", 4'b1110);
        check("overflow_head", dout, 72'hA0);
        for (int i = 0; i < 4; i++) begin
            check("drain_a_dout", dout, 72'hA0 + WIDTH'(i));
            step(0, 1, 0);
        end
        check_flags("drain_a_empty", 4'b0001);

        // Simultaneous write/read while full
        for (int i = 0; i < 4; i++) step(1, 0, 72'hA0 + WIDTH'(i));
        check_flags("refill_full", 4'b1110);
        step(1, 1, 72'hB0);
        check_flags("full_wr_rd_flags", 4'b1110);
        check("full_wr_rd_dout", dout, 72'hA1);
        step(0, 1, 0);
        check("drain_b_1", dout, 72'hA2);
        step(0, 1, 0);
        check("drain_b_2", dout, 72'hA3);
        step(0, 1, 0);
        check("drain_b_3", dout, 72'hB0);
        check_flags("drain_b_last_flags", 4'b0000);
        step(0, 1, 0);
        check_flags("drain_b_empty", 4'b0001);

        // Simultaneous write/read while empty: write accepted
        step(1, 1, 72'hC0);
        check_flags("empty_wr_rd_flags", 4'b0000);
        check("empty_wr_rd_dout", dout, 72'hC0);
        step(0, 1, 0);
        check_flags("c0_drained", 4'b0001);

        // Read while empty must not move the read pointer
        step(0, 1, 0);
        check_flags("underflow_flags", 4'b0001);
        step(1, 0, 72'h77);
        check("after_underflow_dout", dout, 72'h77);
        check_flags("after_underflow_flags", 4'b0000);
        step(0, 1, 0);

        // Streaming 16 words through, pointers wrap several times
        wi = 0;
        ri = 0;
        for (int cyc = 0; cyc < 100 && ri < 16; cyc++) begin
            wr_en = (wi < 16);
            din   = WIDTH'(wi);
            rd_en = !empty;
            if (rd_en) begin
                check("stream_dout", dout, WIDTH'(ri));
                ri++;
            end
            @(posedge clk);
            #1;
            if (wr_en) wi++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("stream_count", WIDTH'(ri), WIDTH'(16));
        check_flags("stream_end_empty", 4'b0001);

        // Reset mid-operation discards contents and dominates wr_en
        step(1, 0, 72'hD0);
        step(1, 0, 72'hD1);
        step(1, 0, 72'hD2);
        check_flags("preload_flags", 4'b0110);
        reset = 1'b1;
        step(1, 0, 72'hEE);
        reset = 1'b0;
        check_flags("mid_reset_flags", 4'b0001);
        step(1, 0, 72'h55);
        check("post_reset_dout", dout, 72'h55);
        check_flags("post_reset_flags", 4'b0000);
        step(0, 1, 0);
        check_flags("post_reset_empty", 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
